// File: rtl/uart_fifo_bridge_pkg.sv
// Shared constants for the UART FIFO bridge and the IO controller that decodes its registers.
package uart_fifo_bridge_pkg;

  localparam int UART_DATA_WIDTH    = 8;
  localparam int FIFO_DEPTH_DEFAULT = 8;

  // CPU IO register offsets, decoded by the IO controller against these same values
  localparam logic [3:0] ADDR_TX_DATA = 4'h0;
  localparam logic [3:0] ADDR_RX_DATA = 4'h4;
  localparam logic [3:0] ADDR_STATUS  = 4'h8;
  localparam logic [3:0] ADDR_COUNT   = 4'hC;

  typedef struct packed {
    logic rx_underflow;
    logic tx_overflow;
    logic rx_valid;
    logic tx_ready;
  } status_t;

endpackage

// File: rtl/uart_fifo_bridge_sync_fifo.sv
// Synchronous show-ahead FIFO with an extra pointer MSB to tell full from empty.
module sync_fifo
  import uart_fifo_bridge_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEFAULT,
  parameter int WIDTH = UART_DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             push_acc;
  logic             pop_acc;

  assign empty    = (wptr == rptr);
  assign full     = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
  assign pop_acc  = pop && !empty;
  // A full FIFO still takes a push when the head leaves in the same cycle
  assign push_acc = push && (!full || pop_acc);
  assign count    = wptr - rptr;
  assign dout     = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_acc) wptr <= wptr + (AW+1)'(1);
      if (pop_acc)  rptr <= rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_acc) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_fifo_bridge.sv
// CPU <-> UART buffering bridge: one TX and one RX sync_fifo plus handshake mapping.
// Sticky overflow/underflow flags are built only when UART_FIFO_ERR_EN is defined.
module uart_fifo_bridge
  import uart_fifo_bridge_pkg::*;
#(
  parameter int TX_DEPTH   = FIFO_DEPTH_DEFAULT,
  parameter int RX_DEPTH   = FIFO_DEPTH_DEFAULT,
  parameter int DATA_WIDTH = UART_DATA_WIDTH
) (
  input  logic                        clk,
  input  logic                        cpu_rst_n,
  input  logic                        tx_push,
  input  logic [DATA_WIDTH-1:0]       tx_wdata,
  output logic                        tx_ready,
  input  logic                        rx_pop,
  output logic [DATA_WIDTH-1:0]       rx_rdata,
  output logic                        rx_valid,
  output logic [$clog2(TX_DEPTH):0]   tx_count,
  output logic [$clog2(RX_DEPTH):0]   rx_count,
  output logic [DATA_WIDTH-1:0]       uart_data_in,
  output logic                        uart_data_in_valid,
  input  logic                        uart_data_in_ready,
  input  logic [DATA_WIDTH-1:0]       uart_data_out,
  input  logic                        uart_data_out_valid,
  output logic                        uart_data_out_ready,
  input  logic                        err_clear,
  output logic                        tx_overflow,
  output logic                        rx_underflow
);

  logic tx_full, tx_empty, tx_pop;
  logic rx_full, rx_empty, rx_push;

  assign tx_pop              = uart_data_in_valid && uart_data_in_ready;
  assign tx_ready            = !tx_full;
  assign uart_data_in_valid  = !tx_empty;
  assign rx_push             = uart_data_out_valid && uart_data_out_ready;
  assign uart_data_out_ready = !rx_full;
  assign rx_valid            = !rx_empty;

  sync_fifo #(.DEPTH(TX_DEPTH), .WIDTH(DATA_WIDTH)) u_tx_fifo (
    .clk   (clk),
    .rst_n (cpu_rst_n),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   (tx_wdata),
    .dout  (uart_data_in),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  sync_fifo #(.DEPTH(RX_DEPTH), .WIDTH(DATA_WIDTH)) u_rx_fifo (
    .clk   (clk),
    .rst_n (cpu_rst_n),
    .push  (rx_push),
    .pop   (rx_pop),
    .din   (uart_data_out),
    .dout  (rx_rdata),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

`ifdef UART_FIFO_ERR_EN
  logic tx_ovf_q;
  logic rx_unf_q;

  // A set event in the same cycle as err_clear takes priority
  always_ff @(posedge clk) begin
    if (!cpu_rst_n) begin
      tx_ovf_q <= 1'b0;
      rx_unf_q <= 1'b0;
    end else begin
      if (tx_push && tx_full && !tx_pop) tx_ovf_q <= 1'b1;
      else if (err_clear)                tx_ovf_q <= 1'b0;
      if (rx_pop && rx_empty)            rx_unf_q <= 1'b1;
      else if (err_clear)                rx_unf_q <= 1'b0;
    end
  end

  assign tx_overflow  = tx_ovf_q;
  assign rx_underflow = rx_unf_q;
`else
  logic unused_err_clear;
  assign unused_err_clear = err_clear;
  assign tx_overflow      = 1'b0;
  assign rx_underflow     = 1'b0;
`endif

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Scoreboard bench for uart_fifo_bridge; expected bytes queue at drive time, compared on handshake.
module tb_uart_fifo_bridge;

  logic       clk = 1'b0;
  logic       cpu_rst_n;
  logic       tx_push;
  logic [7:0] tx_wdata;
  logic       tx_ready;
  logic       rx_pop;
  logic [7:0] rx_rdata;
  logic       rx_valid;
  logic [3:0] tx_count;
  logic [3:0] rx_count;
  logic [7:0] uart_data_in;
  logic       uart_data_in_valid;
  logic       uart_data_in_ready;
  logic [7:0] uart_data_out;
  logic       uart_data_out_valid;
  logic       uart_data_out_ready;
  logic       err_clear;
  logic       tx_overflow;
  logic       rx_underflow;

  int checks = 0;
  int errors = 0;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];

`ifdef UART_FIFO_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  uart_fifo_bridge dut (
    .clk                 (clk),
    .cpu_rst_n           (cpu_rst_n),
    .tx_push             (tx_push),
    .tx_wdata            (tx_wdata),
    .tx_ready            (tx_ready),
    .rx_pop              (rx_pop),
    .rx_rdata            (rx_rdata),
    .rx_valid            (rx_valid),
    .tx_count            (tx_count),
    .rx_count            (rx_count),
    .uart_data_in        (uart_data_in),
    .uart_data_in_valid  (uart_data_in_valid),
    .uart_data_in_ready  (uart_data_in_ready),
    .uart_data_out       (uart_data_out),
    .uart_data_out_valid (uart_data_out_valid),
    .uart_data_out_ready (uart_data_out_ready),
    .err_clear           (err_clear),
    .tx_overflow         (tx_overflow),
    .rx_underflow        (rx_underflow)
  );

  always #5 clk = ~clk;

  // Inputs change 1ns after posedge, so at negedge a handshake seen here commits at the next posedge
  always @(negedge clk) begin
    if (cpu_rst_n && uart_data_in_valid && uart_data_in_ready) begin
      checks++;
      if (tx_q.size() == 0) begin
        errors++;
        $display("FAIL tx_unexpected: got 0x%02h, scoreboard empty", uart_data_in);
      end else begin
        logic [7:0] e;
        e = tx_q.pop_front();
        if (uart_data_in !== e) begin
          errors++;
          $display("FAIL tx_data: got 0x%02h, expected 0x%02h", uart_data_in, e);
        end
      end
    end
    if (cpu_rst_n && rx_pop && rx_valid) begin
      checks++;
      if (rx_q.size() == 0) begin
        errors++;
        $display("FAIL rx_unexpected: got 0x%02h, scoreboard empty", rx_rdata);
      end else begin
        logic [7:0] e;
        e = rx_q.pop_front();
        if (rx_rdata !== e) begin
          errors++;
          $display("FAIL rx_data: got 0x%02h, expected 0x%02h", rx_rdata, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    cpu_rst_n = 1'b0;
    step(2);
    cpu_rst_n = 1'b1;
    checks++;
    if ({tx_ready, rx_valid, uart_data_in_valid, uart_data_out_ready} !== 4'b1001) begin
      errors++;
      $display("FAIL reset_flags: got %b, expected 1001",
               {tx_ready, rx_valid, uart_data_in_valid, uart_data_out_ready});
    end
    checks++;
    if (tx_count !== 4'd0 || rx_count !== 4'd0 || tx_overflow !== 1'b0 || rx_underflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_counts: got tx=%0d rx=%0d ovf=%b unf=%b, expected 0 0 0 0",
               tx_count, rx_count, tx_overflow, rx_underflow);
    end
  endtask

  task automatic test_tx_order();
    uart_data_in_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tx_push  = 1'b1;
      tx_wdata = 8'h41 + 8'(i);
      tx_q.push_back(tx_wdata);
      step();
    end
    tx_push = 1'b0;
    checks++;
    if (tx_count !== 4'd3 || uart_data_in_valid !== 1'b1 || uart_data_in !== 8'h41) begin
      errors++;
      $display("FAIL tx_fill3: got count=%0d valid=%b data=0x%02h, expected 3 1 0x41",
               tx_count, uart_data_in_valid, uart_data_in);
    end
    uart_data_in_ready = 1'b1;
    step(3);
    uart_data_in_ready = 1'b0;
    checks++;
    if (uart_data_in_valid !== 1'b0 || tx_q.size() != 0) begin
      errors++;
      $display("FAIL tx_drain3: got valid=%b pending=%0d, expected 0 0",
               uart_data_in_valid, tx_q.size());
    end
  endtask

  task automatic test_tx_overflow();
    for (int i = 0; i < 9; i++) begin
      tx_push  = 1'b1;
      tx_wdata = 8'(i);
      if (i < 8) tx_q.push_back(tx_wdata);
      step();
      if (i == 7) begin
        checks++;
        if (tx_ready !== 1'b0) begin
          errors++;
          $display("FAIL tx_ready_full: got %b, expected 0", tx_ready);
        end
      end
    end
    tx_push = 1'b0;
    checks++;
    if (tx_count !== 4'd8 || tx_overflow !== ERR_EXP) begin
      errors++;
      $display("FAIL tx_overflow: got count=%0d ovf=%b, expected 8 %b", tx_count, tx_overflow, ERR_EXP);
    end
    step(2);
    checks++;
    if (tx_overflow !== ERR_EXP) begin
      errors++;
      $display("FAIL tx_ovf_sticky: got %b, expected %b", tx_overflow, ERR_EXP);
    end
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    checks++;
    if (tx_overflow !== 1'b0) begin
      errors++;
      $display("FAIL tx_ovf_clear: got %b, expected 0", tx_overflow);
    end
  endtask

  task automatic test_full_push_pop();
    tx_push            = 1'b1;
    tx_wdata           = 8'h55;
    uart_data_in_ready = 1'b1;
    tx_q.push_back(8'h55);
    step();
    tx_push            = 1'b0;
    uart_data_in_ready = 1'b0;
    checks++;
    if (tx_count !== 4'd8 || tx_overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_push_pop: got count=%0d ovf=%b, expected 8 0", tx_count, tx_overflow);
    end
    uart_data_in_ready = 1'b1;
    step(8);
    uart_data_in_ready = 1'b0;
    checks++;
    if (uart_data_in_valid !== 1'b0 || tx_count !== 4'd0 || tx_q.size() != 0) begin
      errors++;
      $display("FAIL full_drain: got valid=%b count=%0d pending=%0d, expected 0 0 0",
               uart_data_in_valid, tx_count, tx_q.size());
    end
  endtask

  task automatic test_rx_backpressure();
    uart_data_out_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      uart_data_out = 8'hA0 + 8'(i);
      rx_q.push_back(uart_data_out);
      step();
    end
    checks++;
    if (uart_data_out_ready !== 1'b0 || rx_count !== 4'd8 || rx_rdata !== 8'hA0) begin
      errors++;
      $display("FAIL rx_full: got ready=%b count=%0d head=0x%02h, expected 0 8 0xa0",
               uart_data_out_ready, rx_count, rx_rdata);
    end
    uart_data_out = 8'hA8;
    step(2);
    checks++;
    if (rx_count !== 4'd8) begin
      errors++;
      $display("FAIL rx_holdoff: got count=%0d, expected 8", rx_count);
    end
    rx_pop = 1'b1;
    step();
    rx_pop = 1'b0;
    checks++;
    if (uart_data_out_ready !== 1'b1 || rx_count !== 4'd7) begin
      errors++;
      $display("FAIL rx_after_pop: got ready=%b count=%0d, expected 1 7", uart_data_out_ready, rx_count);
    end
    rx_q.push_back(8'hA8);
    step();
    uart_data_out_valid = 1'b0;
    checks++;
    if (rx_count !== 4'd8) begin
      errors++;
      $display("FAIL rx_refill: got count=%0d, expected 8", rx_count);
    end
    rx_pop = 1'b1;
    step(8);
    rx_pop = 1'b0;
    checks++;
    if (rx_valid !== 1'b0 || rx_count !== 4'd0 || rx_q.size() != 0) begin
      errors++;
      $display("FAIL rx_drain: got valid=%b count=%0d pending=%0d, expected 0 0 0",
               rx_valid, rx_count, rx_q.size());
    end
  endtask

  task automatic test_rx_underflow();
    rx_pop = 1'b1;
    step();
    rx_pop = 1'b0;
    checks++;
    if (rx_count !== 4'd0 || rx_valid !== 1'b0 || rx_underflow !== ERR_EXP) begin
      errors++;
      $display("FAIL rx_underflow: got count=%0d valid=%b unf=%b, expected 0 0 %b",
               rx_count, rx_valid, rx_underflow, ERR_EXP);
    end
    // Pointers must not have moved: one byte in, one byte out with the right value
    uart_data_out_valid = 1'b1;
    uart_data_out       = 8'h3C;
    rx_q.push_back(8'h3C);
    step();
    uart_data_out_valid = 1'b0;
    checks++;
    if (rx_count !== 4'd1 || rx_rdata !== 8'h3C) begin
      errors++;
      $display("FAIL rx_ptr_still: got count=%0d head=0x%02h, expected 1 0x3c", rx_count, rx_rdata);
    end
    rx_pop    = 1'b1;
    err_clear = 1'b1;
    step();
    rx_pop    = 1'b0;
    err_clear = 1'b0;
    checks++;
    if (rx_underflow !== 1'b0 || rx_count !== 4'd0) begin
      errors++;
      $display("FAIL rx_unf_clear: got unf=%b count=%0d, expected 0 0", rx_underflow, rx_count);
    end
  endtask

  task automatic test_reset_mid();
    uart_data_in_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tx_push  = 1'b1;
      tx_wdata = 8'hC0 + 8'(i);
      step();
    end
    tx_push = 1'b0;
    uart_data_out_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      uart_data_out = 8'hD0 + 8'(i);
      step();
    end
    uart_data_out_valid = 1'b0;
    checks++;
    if (tx_count !== 4'd5 || rx_count !== 4'd3) begin
      errors++;
      $display("FAIL mid_prefill: got tx=%0d rx=%0d, expected 5 3", tx_count, rx_count);
    end
    cpu_rst_n = 1'b0;
    step();
    cpu_rst_n = 1'b1;
    checks++;
    if (tx_count !== 4'd0 || rx_count !== 4'd0 || tx_ready !== 1'b1 || uart_data_in_valid !== 1'b0 ||
        rx_valid !== 1'b0 || uart_data_out_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: got tx=%0d rx=%0d rdy=%b uvld=%b rvld=%b urdy=%b, expected 0 0 1 0 0 1",
               tx_count, rx_count, tx_ready, uart_data_in_valid, rx_valid, uart_data_out_ready);
    end
  endtask

  initial begin
    cpu_rst_n           = 1'b0;
    tx_push             = 1'b0;
    tx_wdata            = 8'h00;
    rx_pop              = 1'b0;
    uart_data_in_ready  = 1'b0;
    uart_data_out       = 8'h00;
    uart_data_out_valid = 1'b0;
    err_clear           = 1'b0;
    test_reset();
    test_tx_order();
    test_tx_overflow();
    test_full_push_pop();
    test_rx_backpressure();
    test_rx_underflow();
    test_reset_mid();
    step(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
